// File: rtl/aer_spike_packetizer.sv
// Packs neuron spikes into AER packets with a timestamp, and adds an end-of-step marker per ts_tick.
// The packet is at out_valid 1 cycle after it is written. A full FIFO or a pending marker drops in_ready. A marker that cannot be queued raises ts_overrun.
module aer_spike_packetizer #(
  parameter  int NEURON_ID_W = 4,
  parameter  int TS_W        = 8,
  parameter  int DEPTH       = 8,
  localparam int PKT_W       = 1 + TS_W + NEURON_ID_W,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [NEURON_ID_W-1:0] in_id,
  output logic                   in_ready,
  input  logic                   ts_tick,
  output logic                   out_valid,
  output logic [PKT_W-1:0]       out_data,
  input  logic                   out_ready,
  output logic [AW:0]            fifo_count,
  output logic                   ts_overrun
);

  localparam int PW = AW + 1;

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [TS_W-1:0]  mk_ts_q, mk_ts_d;
  logic             mk_pend_q, mk_pend_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [PKT_W-1:0] mem_q [DEPTH];

  logic             full, empty, pop, wr_en, mk_drain;
  logic [PKT_W-1:0] wr_dat;

  always_comb begin
    empty      = (wr_ptr_q == rd_ptr_q);
    full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    in_ready   = !full && !mk_pend_q;
    out_valid  = !empty;
    out_data   = mem_q[rd_ptr_q[AW-1:0]];
    pop        = out_valid && out_ready;
    fifo_count = wr_ptr_q - rd_ptr_q;

    // A pending marker has priority over new spikes, so the spikes of a step stay ahead of its marker.
    mk_drain = mk_pend_q && !full;
    wr_en    = 1'b0;
    wr_dat   = '0;
    if (mk_drain) begin
      wr_en  = 1'b1;
      wr_dat = {1'b1, mk_ts_q, {NEURON_ID_W{1'b0}}};
    end else if (in_valid && in_ready) begin
      wr_en  = 1'b1;
      wr_dat = {1'b0, ts_q, in_id};
    end

    // A marker is lost only if the older one cannot leave this cycle either.
    // If the older marker is written this cycle, the new tick simply re-arms the marker.
    ts_overrun = ts_tick && mk_pend_q && full;
    ts_d       = ts_tick ? ts_q + TS_W'(1) : ts_q;
    mk_pend_d  = mk_pend_q && !mk_drain;
    mk_ts_d    = mk_ts_q;
    if (ts_tick && !ts_overrun) begin
      mk_pend_d = 1'b1;
      mk_ts_d   = ts_q;
    end

    wr_ptr_d = wr_ptr_q + PW'(wr_en);
    rd_ptr_d = rd_ptr_q + PW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q      <= '0;
      mk_ts_q   <= '0;
      mk_pend_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      ts_q      <= ts_d;
      mk_ts_q   <= mk_ts_d;
      mk_pend_q <= mk_pend_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
  end

endmodule

// File: tb/tb_aer_spike_packetizer.sv
// Randomised and directed bench for aer_spike_packetizer, checked against a queue-based packet model.
module tb_aer_spike_packetizer;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_id = 4'h0;
  logic        ts_tick = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, ts_overrun;
  logic [12:0] out_data;
  logic [3:0]  fifo_count;

  aer_spike_packetizer #(.NEURON_ID_W(4), .TS_W(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_id(in_id), .in_ready(in_ready),
    .ts_tick(ts_tick), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .fifo_count(fifo_count), .ts_overrun(ts_overrun)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [12:0] mq[$];
  int          m_ts = 0;
  bit          m_pend = 1'b0;
  int          m_mkts = 0;
  logic [12:0] last_pop = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ts = 0;
    m_pend = 1'b0;
    m_mkts = 0;
  endtask

  // Packet-level rules: the model pops the head, then appends either the pending marker or the offered spike.
  task automatic model_advance();
    bit full, pend0;
    full  = (mq.size() == DEPTH);
    pend0 = m_pend;
    if (mq.size() != 0 && out_ready) void'(mq.pop_front());
    if (pend0 && !full) begin
      mq.push_back({1'b1, 8'(m_mkts), 4'h0});
      m_pend = 1'b0;
    end else if (in_valid && !full && !pend0) begin
      mq.push_back({1'b0, 8'(m_ts), in_id});
    end
    if (ts_tick) begin
      if (!(pend0 && full)) begin
        m_pend = 1'b1;
        m_mkts = m_ts;
      end
      m_ts = (m_ts + 1) % 256;
    end
  endtask

  task automatic drive(input bit v, input logic [3:0] id, input bit tk, input bit rdy);
    in_valid  = v;
    in_id     = id;
    ts_tick   = tk;
    out_ready = rdy;
  endtask

  task automatic step();
    @(negedge clk);
    check("out_valid", out_valid, mq.size() != 0);
    check("fifo_count", fifo_count, mq.size());
    check("in_ready", in_ready, (mq.size() < DEPTH) && !m_pend);
    check("ts_overrun", ts_overrun, ts_tick && m_pend && (mq.size() == DEPTH));
    if (mq.size() != 0) check("out_data", out_data, mq[0]);
    if (out_valid && out_ready) last_pop = out_data;
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit v, input logic [3:0] id, input bit tk, input bit rdy);
    drive(v, id, tk, rdy);
    step();
  endtask

  initial begin
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_ts_overrun", ts_overrun, 0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic spike: id 5 at ts 0 appears on the next cycle.
    cyc(1, 4'h5, 0, 1);
    check("basic_valid", out_valid, 1);
    check("basic_data", out_data, 13'h005);
    check("basic_count", fifo_count, 1);
    cyc(0, 0, 0, 1);

    // A spike and a tick in the same cycle: the spike comes first, then the marker for step 0.
    cyc(1, 4'h3, 1, 0);
    check("tick_in_ready_low", in_ready, 0);
    check("tick_spike_data", out_data, 13'h003);
    cyc(0, 0, 0, 0);
    check("tick_in_ready_back", in_ready, 1);
    check("tick_count", fifo_count, 2);
    cyc(0, 0, 0, 1);
    check("tick_marker_data", out_data, 13'h1000);
    cyc(1, 4'h7, 0, 1);
    check("tick_next_ts", out_data, 13'h017);
    cyc(0, 0, 0, 1);

    // Full FIFO: the marker waits for one pop, then is written on the following cycle.
    for (int i = 0; i < 8; i++) cyc(1, 4'(i), 0, 0);
    check("full_count", fifo_count, 8);
    check("full_in_ready", in_ready, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    check("full_after_pop", fifo_count, 7);
    cyc(0, 0, 0, 0);
    check("full_marker_in", fifo_count, 8);

    // Overrun: two ticks while full; only the first timestamp survives.
    cyc(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    #1;
    check("overrun_pulse", ts_overrun, 1);
    step();
    drive(0, 0, 0, 0);
    #1;
    check("overrun_single", ts_overrun, 0);
    step();
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 1);
    check("overrun_drained", fifo_count, 0);
    check("overrun_last_marker", last_pop, 13'h1020);
    cyc(1, 4'h9, 0, 0);
    check("overrun_ts_after", out_data, 13'h049);
    cyc(0, 0, 0, 1);

    // Timestep wrap: the final marker carries 0xFF, and the following spike carries 0x00.
    for (int i = 0; i < 252; i++) cyc(0, 0, 1, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
    check("wrap_last_marker", last_pop, 13'h1FF0);
    cyc(1, 4'h2, 0, 1);
    check("wrap_spike", out_data, 13'h002);
    cyc(0, 0, 0, 1);

    // Reset mid-stream with 5 packets queued and a marker pending.
    for (int i = 0; i < 4; i++) cyc(1, 4'(i), 0, 0);
    cyc(1, 4'h4, 1, 0);
    check("mid_count", fifo_count, 5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_in_ready", in_ready, 1);
    model_reset();
    drive(0, 0, 0, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1, 4'h6, 0, 0);
    check("post_rst_data", out_data, 13'h006);
    check("post_rst_count", fifo_count, 1);

    // Random traffic with varying backpressure.
    for (int blk = 0; blk < 20; blk++) begin
      int rdy_pct;
      rdy_pct = $urandom_range(0, 100);
      for (int i = 0; i < 200; i++) begin
        cyc($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
            $urandom_range(0, 9) == 0, $urandom_range(1, 100) <= rdy_pct);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
